// File: rtl/led_pwm_bank_if.sv
// Configuration bus for led_pwm_bank: one channel (mode + duty) written per strobe.
interface led_pwm_bank_if #(
    parameter int N_LED    = 7,
    parameter int PWM_BITS = 8
);
    localparam int SELW = (N_LED > 1) ? $clog2(N_LED) : 1;

    logic                cfg_we;
    logic [SELW-1:0]     cfg_sel;
    logic [1:0]          cfg_mode;
    logic [PWM_BITS-1:0] cfg_duty;

    modport master (output cfg_we, cfg_sel, cfg_mode, cfg_duty);
    modport slave  (input  cfg_we, cfg_sel, cfg_mode, cfg_duty);
endinterface

// File: rtl/led_pwm_bank.sv
// Bank of phase-aligned LED PWM channels sharing one prescaler, PWM counter,
// blink phase and breathe ramp; per-channel mode/duty set through a config bus.
module led_pwm_bank #(
    parameter int N_LED        = 7,
    parameter int PWM_BITS     = 8,
    parameter int PRESC        = 16,
    parameter int BLINK_FRAMES = 32,
    parameter bit RESET_ON     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    led_pwm_bank_if.slave    cfg,
    output logic [N_LED-1:0] led,
    output logic             frame_tick
);
    localparam int SELW = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam int PREW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int BFW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PREW-1:0]     PRE_LAST = PREW'(PRESC - 1);
    localparam logic [BFW-1:0]      BF_LAST  = BFW'(BLINK_FRAMES - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = {PWM_BITS{1'b1}};

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    localparam logic [1:0]          MODE_RST = RESET_ON ? MODE_ON : MODE_OFF;
    localparam logic [PWM_BITS-1:0] DUTY_RST = {PWM_BITS{RESET_ON}};

    logic [PREW-1:0]     pre_cnt;
    logic [PWM_BITS-1:0] pwm;
    logic [BFW-1:0]      blink_cnt;
    logic                blink_ph;
    logic [PWM_BITS-1:0] lvl;
    logic                dir_up;

    logic                step;
    logic                wrap;
    logic                blink_tc;

    logic [1:0]          mode  [N_LED];
    logic [PWM_BITS-1:0] duty  [N_LED];
    logic [PWM_BITS-1:0] d_eff [N_LED];
    logic [N_LED-1:0]    led_nxt;

    // Prescaler and blink frame counter run downward; terminal count is zero.
    assign step     = (pre_cnt == '0);
    assign wrap     = step && (pwm == PWM_MAX);
    assign blink_tc = (blink_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt    <= PRE_LAST;
            pwm        <= '0;
            blink_cnt  <= BF_LAST;
            blink_ph   <= 1'b0;
            lvl        <= '0;
            dir_up     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            pre_cnt    <= step ? PRE_LAST : pre_cnt - 1'b1;
            frame_tick <= wrap;
            if (step) begin
                pwm <= pwm + 1'b1;
            end
            if (wrap) begin
                blink_cnt <= blink_tc ? BF_LAST : blink_cnt - 1'b1;
                if (blink_tc) begin
                    blink_ph <= ~blink_ph;
                end
                // Turn-around frames hold the end level for one extra frame.
                if (dir_up) begin
                    if (lvl == PWM_MAX) dir_up <= 1'b0;
                    else                lvl    <= lvl + 1'b1;
                end else begin
                    if (lvl == '0) dir_up <= 1'b1;
                    else           lvl    <= lvl - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LED; i++) begin
                mode[i] <= MODE_RST;
                duty[i] <= DUTY_RST;
            end
        end else if (cfg.cfg_we) begin
            // Out-of-range selects match no channel and are dropped.
            for (int i = 0; i < N_LED; i++) begin
                if (cfg.cfg_sel == SELW'(i)) begin
                    mode[i] <= cfg.cfg_mode;
                    duty[i] <= cfg.cfg_duty;
                end
            end
        end
    end

    always_comb begin
        led_nxt = '0;
        for (int i = 0; i < N_LED; i++) begin
            unique case (mode[i])
                MODE_OFF:     d_eff[i] = '0;
                MODE_ON:      d_eff[i] = duty[i];
                MODE_BLINK:   d_eff[i] = blink_ph ? duty[i] : '0;
                MODE_BREATHE: d_eff[i] = (lvl < duty[i]) ? lvl : duty[i];
                default:      d_eff[i] = '0;
            endcase
            // Full-scale duty forces solid on so there is no dark step at pwm=max.
            led_nxt[i] = (d_eff[i] == PWM_MAX) || (pwm < d_eff[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) led <= '0;
        else        led <= led_nxt;
    end
endmodule

// File: tb/tb_led_pwm_bank.sv
// Self-checking bench for led_pwm_bank: a cycle-count based reference model checks
// every cycle, plus a config-vector table and hand sequences for blink/breathe/reset.
`timescale 1ns/1ps
module tb_led_pwm_bank;
    localparam int NA = 4, PBA = 4, PRA = 2, BFA = 2, SELWA = 2;
    localparam int NB = 1, PBB = 2, PRB = 1, BFB = 1, SELWB = 1;
    localparam int FRA = PRA * (1 << PBA);
    localparam int FRB = PRB * (1 << PBB);
    localparam int MD_OFF = 0, MD_ON = 1, MD_BLINK = 2, MD_BREATHE = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_pwm_bank_if #(.N_LED(NA), .PWM_BITS(PBA)) ifa ();
    led_pwm_bank_if #(.N_LED(NB), .PWM_BITS(PBB)) ifb ();

    logic [NA-1:0] led_a;
    logic          ft_a;
    logic [NB-1:0] led_b;
    logic          ft_b;

    led_pwm_bank #(.N_LED(NA), .PWM_BITS(PBA), .PRESC(PRA), .BLINK_FRAMES(BFA), .RESET_ON(1'b1))
        dut_a (.clk(clk), .rst_n(rst_n), .cfg(ifa), .led(led_a), .frame_tick(ft_a));
    led_pwm_bank #(.N_LED(NB), .PWM_BITS(PBB), .PRESC(PRB), .BLINK_FRAMES(BFB), .RESET_ON(1'b0))
        dut_b (.clk(clk), .rst_n(rst_n), .cfg(ifb), .led(led_b), .frame_tick(ft_b));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: everything is a function of k, the number of clocks since reset release.
    function automatic bit model_bit(int k, int presc, int pb, int bf, int md, int dt);
        int m, s, pw, f, ph, p, lv, d;
        m  = 1 << pb;
        s  = k / presc;
        pw = s % m;
        f  = s / m;
        ph = (f / bf) % 2;
        p  = f % (2 * m);
        lv = (p < m) ? p : (2 * m - 1 - p);
        case (md)
            MD_OFF:   d = 0;
            MD_ON:    d = dt;
            MD_BLINK: d = (ph == 1) ? dt : 0;
            default:  d = (lv < dt) ? lv : dt;
        endcase
        return (d == m - 1) || (pw < d);
    endfunction

    int k;
    int mode_a [NA], duty_a [NA], mode_b [NB], duty_b [NB];
    logic [NA-1:0] exp_led_a;
    logic [NB-1:0] exp_led_b;
    logic exp_ft_a, exp_ft_b;

    always @(posedge clk) begin
        if (!rst_n) begin
            k = 0;
            for (int i = 0; i < NA; i++) begin mode_a[i] = MD_ON;  duty_a[i] = 15; end
            for (int i = 0; i < NB; i++) begin mode_b[i] = MD_OFF; duty_b[i] = 0;  end
            exp_led_a = '0; exp_led_b = '0; exp_ft_a = 1'b0; exp_ft_b = 1'b0;
        end else begin
            for (int i = 0; i < NA; i++) exp_led_a[i] = model_bit(k, PRA, PBA, BFA, mode_a[i], duty_a[i]);
            for (int i = 0; i < NB; i++) exp_led_b[i] = model_bit(k, PRB, PBB, BFB, mode_b[i], duty_b[i]);
            k++;
            exp_ft_a = (k % FRA == 0);
            exp_ft_b = (k % FRB == 0);
            if (ifa.cfg_we && int'(ifa.cfg_sel) < NA) begin
                mode_a[ifa.cfg_sel] = int'(ifa.cfg_mode);
                duty_a[ifa.cfg_sel] = int'(ifa.cfg_duty);
            end
            if (ifb.cfg_we && int'(ifb.cfg_sel) < NB) begin
                mode_b[ifb.cfg_sel] = int'(ifb.cfg_mode);
                duty_b[ifb.cfg_sel] = int'(ifb.cfg_duty);
            end
        end
    end

    always @(negedge clk) begin
        chk("led_a", 32'(led_a), 32'(exp_led_a));
        chk("ft_a",  32'(ft_a),  32'(exp_ft_a));
        chk("led_b", 32'(led_b), 32'(exp_led_b));
        chk("ft_b",  32'(ft_b),  32'(exp_ft_b));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_a(input int sel, input int md, input int dt);
        ifa.cfg_we = 1'b1; ifa.cfg_sel = SELWA'(sel); ifa.cfg_mode = 2'(md); ifa.cfg_duty = PBA'(dt);
        @(negedge clk);
        ifa.cfg_we = 1'b0;
    endtask

    task automatic wr_b(input int sel, input int md, input int dt);
        ifb.cfg_we = 1'b1; ifb.cfg_sel = SELWB'(sel); ifb.cfg_mode = 2'(md); ifb.cfg_duty = PBB'(dt);
        @(negedge clk);
        ifb.cfg_we = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        cyc(n);
        rst_n = 1'b1;
    endtask

    task automatic wait_ft_a();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * FRA; i++) begin
            if (ft_a) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("ft_a_timeout", 32'(ok), 32'd1);
    endtask

    // Per-frame high counts of ch3 in breathe mode, frames 0..33 after release.
    task automatic breathe_run(input int dt);
        int cnt, f, p, lv, d, e;
        do_reset(2);
        wr_a(3, MD_BREATHE, dt);
        cnt = 0;
        for (int j = 2; j <= 34 * FRA; j++) begin
            @(negedge clk);
            if (led_a[3]) cnt++;
            if (j % FRA == 0) begin
                f  = (j - 1) / FRA;
                p  = f % 32;
                lv = (p < 16) ? p : 31 - p;
                d  = (lv < dt) ? lv : dt;
                e  = (d == 15) ? FRA : PRA * d;
                chk("breathe_frame", 32'(cnt), 32'(e));
                cnt = 0;
            end
        end
    endtask

    typedef struct {
        int sel;
        int md;
        int dt;
        int ch;
        int exp_cnt;
    } vec_t;

    initial begin
        vec_t tbl [7];
        int cnt, cnt2;

        tbl[0] = '{1, MD_ON,  4,  1, 8};
        tbl[1] = '{1, MD_ON,  0,  1, 0};
        tbl[2] = '{1, MD_ON,  15, 1, 32};
        tbl[3] = '{0, MD_OFF, 9,  0, 0};
        tbl[4] = '{0, MD_ON,  9,  0, 18};
        tbl[5] = '{2, MD_ON,  1,  2, 2};
        tbl[6] = '{1, MD_ON,  4,  0, 18};

        ifa.cfg_we = 1'b0; ifa.cfg_sel = '0; ifa.cfg_mode = '0; ifa.cfg_duty = '0;
        ifb.cfg_we = 1'b0; ifb.cfg_sel = '0; ifb.cfg_mode = '0; ifb.cfg_duty = '0;
        rst_n = 1'b0;

        // Reset with RESET_ON=1: dark during reset, solid on afterwards.
        cyc(2);
        chk("reset_led_a", 32'(led_a), 32'h0);
        chk("reset_ft_a",  32'(ft_a),  32'h0);
        chk("reset_led_b", 32'(led_b), 32'h0);
        rst_n = 1'b1;
        cnt = 0; cnt2 = 0;
        for (int j = 1; j <= 3 * FRA; j++) begin
            @(negedge clk);
            if (led_a == 4'hF) cnt++;
            if (ft_a) cnt2++;
        end
        chk("reset_on_solid", 32'(cnt), 32'(3 * FRA));
        chk("ft_a_pulses", 32'(cnt2), 32'd3);

        for (int t = 0; t < 7; t++) begin
            wr_a(tbl[t].sel, tbl[t].md, tbl[t].dt);
            cyc(1);
            wait_ft_a();
            cnt = 0;
            for (int j = 0; j < FRA; j++) begin
                if (led_a[tbl[t].ch]) cnt++;
                @(negedge clk);
            end
            chk("table_frame_high", 32'(cnt), 32'(tbl[t].exp_cnt));
        end

        // Small instance: 4-cycle frame, duty 2, then an out-of-range select.
        wr_b(0, MD_ON, 2);
        cyc(1);
        cnt = 0; cnt2 = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (led_b[0]) cnt++;
            if (ft_b) cnt2++;
        end
        chk("b_duty2_high", 32'(cnt), 32'd8);
        chk("b_ft_pulses",  32'(cnt2), 32'd4);
        wr_b(1, MD_ON, 3);
        cyc(1);
        cnt = 0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (led_b[0]) cnt++;
        end
        chk("b_bad_sel_ignored", 32'(cnt), 32'd8);

        // Write in the same cycle as reset is lost.
        rst_n = 1'b0;
        ifa.cfg_we = 1'b1; ifa.cfg_sel = 2'd0; ifa.cfg_mode = 2'(MD_OFF); ifa.cfg_duty = '0;
        ifb.cfg_we = 1'b1; ifb.cfg_sel = 1'b0; ifb.cfg_mode = 2'(MD_ON);  ifb.cfg_duty = 2'd3;
        cyc(1);
        ifa.cfg_we = 1'b0; ifb.cfg_we = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        chk("rst_write_dropped_a", 32'(led_a), 32'hF);
        chk("rst_write_dropped_b", 32'(led_b), 32'h0);

        // Blink: low for the first 64 cycles after release, then high for 64.
        do_reset(2);
        wr_a(2, MD_BLINK, 15);
        cnt = 0; cnt2 = 0;
        for (int j = 2; j <= 160; j++) begin
            @(negedge clk);
            if (j <= 64 && led_a[2]) cnt++;
            if (j >= 65 && j <= 128 && led_a[2]) cnt2++;
            if (j == 140) chk("blink_low_again", 32'(led_a[2]), 32'd0);
        end
        chk("blink_first_low",  32'(cnt),  32'd0);
        chk("blink_second_high", 32'(cnt2), 32'd64);

        breathe_run(15);
        breathe_run(8);

        // Randomized writes and occasional resets against the reference model.
        for (int n = 0; n < 800; n++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            ifa.cfg_we   = ($urandom_range(0, 5) == 0);
            ifa.cfg_sel  = SELWA'($urandom_range(0, 3));
            ifa.cfg_mode = 2'($urandom_range(0, 3));
            ifa.cfg_duty = PBA'($urandom_range(0, 15));
            ifb.cfg_we   = ($urandom_range(0, 5) == 0);
            ifb.cfg_sel  = SELWB'($urandom_range(0, 1));
            ifb.cfg_mode = 2'($urandom_range(0, 3));
            ifb.cfg_duty = PBB'($urandom_range(0, 3));
            cyc(1);
        end
        rst_n = 1'b1;
        ifa.cfg_we = 1'b0;
        ifb.cfg_we = 1'b0;
        cyc(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end
endmodule
